qpsk_demodulate: RTL and testbench
==================================

// Module: qpsk_demodulate
// PURPOSE
//   Receive-side counterpart of the QPSK modulator. Consumes the 9-bit offset-binary carrier
//   samples the modulator emits, correlates each symbol period against sign-of-cos and
//   sign-of-sin references, and recovers one Ichannel/Qchannel bit pair per symbol.
//   Sits between the sample source (loopback from modulator or ADC path) and the bit sink.
// PARAMETERS
//   SAMPLES_PER_SYM  16  samples per symbol N; multiple of 4, >= 4
//   ACC_W            16  signed accumulator width; must be >= 10 + clog2(SAMPLES_PER_SYM)
// PORTS
//   clk          in   1      single clock, all logic on posedge
//   rst          in   1      synchronous, active-high reset
//   QPSK_in      in   9      carrier sample, unsigned offset-binary, midscale 256
//   sample_valid in   1      QPSK_in valid this cycle
//   sym_start    in   1      qualified by sample_valid: this sample is symbol index 0
//   Ichannel     out  1      recovered I bit, held until next decision
//   Qchannel     out  1      recovered Q bit, held until next decision
//   bits_valid   out  1      one-cycle pulse: new Ichannel/Qchannel this cycle
//   sync_err     out  1      one-cycle pulse: sym_start arrived mid-symbol
// BEHAVIOUR
//   Reset: state IDLE, idx=0, acc_i=acc_q=0; Ichannel=Qchannel=bits_valid=sync_err=0.
//   Sample: s = signed{1'b0,QPSK_in} - 256 (10-bit, range -256..255), sign-extended to ACC_W.
//   Reference at index n: c(n)=+1 if n<N/4 or n>=3N/4 else -1; q(n)=+1 if n<N/2 else -1.
//   Contribution: acc_i += c(n)*s, acc_q += q(n)*s; never saturates (width rule guarantees).
//   States:
//     IDLE  - ignore samples until sample_valid&&sym_start; then acc := contribution of n=0,
//             idx:=1, go TRACK.
//     TRACK - each sample_valid: accumulate at idx, idx++. Cycles without sample_valid: hold.
//             On sample at idx=N-1: final sums (acc + this contribution) decide the symbol;
//             registered at the same edge, so bits_valid=1 the cycle after the last sample.
//             Ichannel = (final acc_i < 0), Qchannel = (final acc_q < 0); a sum of 0 -> bit 0.
//             idx wraps to 0, acc cleared; stay in TRACK (free-running, sym_start optional at idx 0).
//   sym_start at idx=0: normal, no error. sym_start at idx!=0 in TRACK: discard partial sums,
//     restart with this sample as n=0 (idx:=1), sync_err=1 next cycle, no bits_valid.
//   sym_start without sample_valid: ignored.
//   Back-to-back symbols with continuous sample_valid: bits_valid every N cycles, no bubble.
//   rst mid-symbol: partial sums lost, outputs to reset values next cycle, return to IDLE.
//   Ichannel/Qchannel change only on cycles where bits_valid=1.
//   Latency: last sample of symbol at edge k -> bits_valid and decided bits visible after edge k.
// CONFIGURATION
//   DEMOD_SOFT_OUT_EN defined: adds outputs soft_i, soft_q [ACC_W-1:0] signed, registered
//     with the final acc_i/acc_q of each symbol, updating exactly when bits_valid pulses;
//     reset 0; hold otherwise.
//   Not defined: ports and registers absent; hard decisions only, behaviour otherwise identical.
// TESTING
//   1. rst high 3 cycles -> Ichannel=Qchannel=bits_valid=sync_err=0; QPSK_in toggling w/o sym_start -> no pulses.
//   2. N=16, sym_start at n=0, QPSK_in=256+100*c(n)+100*q(n) -> bits_valid one cycle after 16th sample,
//      I=0, Q=0; with SOFT_OUT: soft_i=1600, soft_q=1600.
//   3. Four back-to-back symbols, signs (+,+),(+,-),(-,-),(-,+) amp 100, continuous valid ->
//      bits_valid every 16 cycles, (I,Q) = 00, 01, 11, 10.
//   4. sample_valid low every other cycle for symbol 3 of test 3 -> same (1,1), pulse after 16th valid sample.
//   5. sym_start reasserted at idx=7 -> sync_err pulse next cycle, no bits_valid for partial,
//      decision 16 samples after the restart.
//   6. QPSK_in=256 constant for full symbol -> acc 0, I=0, Q=0; rst at idx=10 -> IDLE, no pulse.

Source files
------------

// File: rtl/qpsk_demodulate.sv
// ============================================================================
// Module   : qpsk_demodulate
// Summary  : QPSK hard-decision demodulator. Correlates each symbol period of
//            offset-binary carrier samples against sign-of-cos and sign-of-sin
//            references and emits one I/Q bit pair per symbol.
//            Optional: define DEMOD_SOFT_OUT_EN to expose soft_i/soft_q.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qpsk_demodulate #(
    parameter int SAMPLES_PER_SYM = 16,
    parameter int ACC_W           = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8:0]              QPSK_in,
    input  logic                    sample_valid,
    input  logic                    sym_start,
    output logic                    Ichannel,
    output logic                    Qchannel,
    output logic                    bits_valid,
    output logic                    sync_err
`ifdef DEMOD_SOFT_OUT_EN
    ,
    output logic signed [ACC_W-1:0] soft_i,
    output logic signed [ACC_W-1:0] soft_q
`endif
);

    localparam int                 c_IDX_W = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(SAMPLES_PER_SYM - 1);
    localparam logic [c_IDX_W-1:0] c_ONE   = c_IDX_W'(1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_TRACK = 1'b1;

    logic [0:0]               r_state;
    logic [c_IDX_W-1:0]       r_idx;
    logic signed [ACC_W-1:0]  r_acc_i;
    logic signed [ACC_W-1:0]  r_acc_q;
    logic                     r_ichannel;
    logic                     r_qchannel;
    logic                     r_bits_valid;
    logic                     r_sync_err;

    // Reference sign tables: bit set means +1, clear means -1.
    logic [SAMPLES_PER_SYM-1:0] w_cref;
    logic [SAMPLES_PER_SYM-1:0] w_qref;

    for (genvar n = 0; n < SAMPLES_PER_SYM; n++) begin : g_ref
        assign w_cref[n] = (n < SAMPLES_PER_SYM / 4) || (n >= (3 * SAMPLES_PER_SYM) / 4);
        assign w_qref[n] = (n < SAMPLES_PER_SYM / 2);
    end

    logic signed [9:0]        w_s;
    logic signed [ACC_W-1:0]  w_s_ext;
    logic signed [ACC_W-1:0]  w_s_neg;
    logic                     w_restart;
    logic [c_IDX_W-1:0]       w_n;
    logic signed [ACC_W-1:0]  w_base_i;
    logic signed [ACC_W-1:0]  w_base_q;
    logic signed [ACC_W-1:0]  w_sum_i;
    logic signed [ACC_W-1:0]  w_sum_q;
    logic                     w_last;

    assign w_s     = $signed({1'b0, QPSK_in}) - 10'sd256;
    assign w_s_ext = {{(ACC_W - 10){w_s[9]}}, w_s};
    assign w_s_neg = -w_s_ext;

    // A qualified sym_start begins a fresh symbol unless it lands exactly on index 0.
    assign w_restart = sample_valid && sym_start && ((r_state == c_IDLE) || (r_idx != '0));
    assign w_n       = w_restart ? '0 : r_idx;
    assign w_base_i  = w_restart ? '0 : r_acc_i;
    assign w_base_q  = w_restart ? '0 : r_acc_q;
    assign w_sum_i   = w_base_i + (w_cref[w_n] ? w_s_ext : w_s_neg);
    assign w_sum_q   = w_base_q + (w_qref[w_n] ? w_s_ext : w_s_neg);
    assign w_last    = !w_restart && (w_n == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_idx        <= '0;
            r_acc_i      <= '0;
            r_acc_q      <= '0;
            r_ichannel   <= 1'b0;
            r_qchannel   <= 1'b0;
            r_bits_valid <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_bits_valid <= 1'b0;
            r_sync_err   <= 1'b0;
            if (sample_valid) begin
                if (w_restart) begin
                    r_acc_i    <= w_sum_i;
                    r_acc_q    <= w_sum_q;
                    r_idx      <= c_ONE;
                    r_state    <= c_TRACK;
                    r_sync_err <= (r_state == c_TRACK);
                end else if (r_state == c_TRACK) begin
                    if (w_last) begin
                        r_ichannel   <= w_sum_i[ACC_W-1];
                        r_qchannel   <= w_sum_q[ACC_W-1];
                        r_bits_valid <= 1'b1;
                        r_acc_i      <= '0;
                        r_acc_q      <= '0;
                        r_idx        <= '0;
                    end else begin
                        r_acc_i <= w_sum_i;
                        r_acc_q <= w_sum_q;
                        r_idx   <= r_idx + c_ONE;
                    end
                end
            end
        end
    end

`ifdef DEMOD_SOFT_OUT_EN
    logic signed [ACC_W-1:0] r_soft_i;
    logic signed [ACC_W-1:0] r_soft_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_soft_i <= '0;
            r_soft_q <= '0;
        end else if (sample_valid && (r_state == c_TRACK) && w_last) begin
            r_soft_i <= w_sum_i;
            r_soft_q <= w_sum_q;
        end
    end

    assign soft_i = r_soft_i;
    assign soft_q = r_soft_q;
`endif

    assign Ichannel   = r_ichannel;
    assign Qchannel   = r_qchannel;
    assign bits_valid = r_bits_valid;
    assign sync_err   = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_qpsk_demodulate.sv
// ============================================================================
// Module   : tb_qpsk_demodulate
// Summary  : Scoreboard bench for qpsk_demodulate (N=16, ACC_W=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qpsk_demodulate;

    localparam int N = 16;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [8:0]    QPSK_in = 9'd256;
    logic          sample_valid = 1'b0;
    logic          sym_start = 1'b0;
    logic          Ichannel;
    logic          Qchannel;
    logic          bits_valid;
    logic          sync_err;
`ifdef DEMOD_SOFT_OUT_EN
    logic signed [W-1:0] soft_i;
    logic signed [W-1:0] soft_q;
`endif

    qpsk_demodulate #(.SAMPLES_PER_SYM(N), .ACC_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .QPSK_in      (QPSK_in),
        .sample_valid (sample_valid),
        .sym_start    (sym_start),
        .Ichannel     (Ichannel),
        .Qchannel     (Qchannel),
        .bits_valid   (bits_valid),
        .sync_err     (sync_err)
`ifdef DEMOD_SOFT_OUT_EN
        ,
        .soft_i       (soft_i),
        .soft_q       (soft_q)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    logic rst_cap = 1'b1;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_cap <= rst;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [1:0] iq;
        longint     si;
        longint     sq;
    } exp_t;

    exp_t bq[$];
    int   seq[$];

    // Spec-level model state
    bit m_track = 0;
    int m_idx   = 0;
    int m_ai    = 0;
    int m_aq    = 0;

    function automatic int cref(input int n);
        return ((n < N / 4) || (n >= 3 * N / 4)) ? 1 : -1;
    endfunction

    function automatic int qref(input int n);
        return (n < N / 2) ? 1 : -1;
    endfunction

    task automatic drive(input int v, input bit valid, input bit start);
        int   s;
        int   c;
        exp_t e;
        QPSK_in      = 9'(v);
        sample_valid = valid;
        sym_start    = start;
        @(posedge clk);
        #1;
        c = cyc;
        s = v - 256;
        if (valid) begin
            if (start && (!m_track || m_idx != 0)) begin
                if (m_track) seq.push_back(c);
                m_ai    = s * cref(0);
                m_aq    = s * qref(0);
                m_idx   = 1;
                m_track = 1;
            end else if (m_track) begin
                m_ai += s * cref(m_idx);
                m_aq += s * qref(m_idx);
                if (m_idx == N - 1) begin
                    e.cyc = c;
                    e.iq  = {m_ai < 0, m_aq < 0};
                    e.si  = m_ai;
                    e.sq  = m_aq;
                    bq.push_back(e);
                    m_ai  = 0;
                    m_aq  = 0;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(256, 0, 0);
    endtask

    task automatic send_sym(input int a, input int b, input bit start, input bit gaps,
                            input int count);
        for (int n = 0; n < count; n++) begin
            drive(256 + a * cref(n) + b * qref(n), 1, start && (n == 0));
            if (gaps) drive(0, 0, 1);
        end
    endtask

    task automatic do_reset(input int n);
        rst          = 1'b1;
        sample_valid = 1'b0;
        sym_start    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst     = 1'b0;
        m_track = 0;
        m_idx   = 0;
        m_ai    = 0;
        m_aq    = 0;
        chk("rst_I", Ichannel, 0);
        chk("rst_Q", Qchannel, 0);
        chk("rst_bits_valid", bits_valid, 0);
        chk("rst_sync_err", sync_err, 0);
    endtask

    logic [1:0] prev_iq = 2'b00;
    exp_t       mon_e;
    int         mon_c;

    always @(negedge clk) begin
        if (rst_cap) begin
            prev_iq = {Ichannel, Qchannel};
        end else begin
            if (bits_valid) begin
                if (bq.size() == 0) begin
                    chk("unexpected_bits_valid", 1, 0);
                end else begin
                    mon_e = bq.pop_front();
                    chk("bv_cycle", cyc, mon_e.cyc);
                    chk("iq", {Ichannel, Qchannel}, mon_e.iq);
`ifdef DEMOD_SOFT_OUT_EN
                    chk("soft_i", soft_i, mon_e.si);
                    chk("soft_q", soft_q, mon_e.sq);
`endif
                end
            end else begin
                chk("iq_hold", {Ichannel, Qchannel}, prev_iq);
            end
            if (sync_err) begin
                if (seq.size() == 0) begin
                    chk("unexpected_sync_err", 1, 0);
                end else begin
                    mon_c = seq.pop_front();
                    chk("sync_err_cycle", cyc, mon_c);
                end
            end
            prev_iq = {Ichannel, Qchannel};
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset, then samples without sym_start must stay silent
        do_reset(3);
        for (int i = 0; i < 20; i++) drive((i % 2) ? 400 : 100, 1, 0);
        idle(2);

        // 2: single (+,+) symbol
        send_sym(100, 100, 1, 0, N);
        idle(3);
        chk("sym1_I", Ichannel, 0);
        chk("sym1_Q", Qchannel, 0);
`ifdef DEMOD_SOFT_OUT_EN
        chk("sym1_soft_i", soft_i, 1600);
        chk("sym1_soft_q", soft_q, 1600);
`endif

        // 3: four back-to-back symbols, start pulse at idx 0 on the third
        send_sym(100, 100, 1, 0, N);
        send_sym(100, -100, 0, 0, N);
        send_sym(-100, -100, 1, 0, N);
        send_sym(-100, 100, 0, 0, N);
        chk("b2b_last_I", Ichannel, 1);
        chk("b2b_last_Q", Qchannel, 0);

        // 4: (-,-) symbol with sample_valid low every other cycle
        send_sym(-100, -100, 0, 1, N);
        idle(2);
        chk("gap_I", Ichannel, 1);
        chk("gap_Q", Qchannel, 1);

        // 5: resync at idx 7
        send_sym(100, 100, 0, 0, 7);
        send_sym(-100, 100, 1, 0, N);
        idle(2);
        chk("resync_I", Ichannel, 1);
        chk("resync_Q", Qchannel, 0);

        // 6: midscale symbol, then reset mid-symbol
        send_sym(0, 0, 0, 0, N);
        idle(2);
        chk("zero_I", Ichannel, 0);
        chk("zero_Q", Qchannel, 0);
        send_sym(-100, -100, 0, 0, N);
        send_sym(100, -100, 0, 0, 10);
        do_reset(1);
        for (int i = 0; i < 10; i++) drive(150, 1, 0);
        idle(4);

        chk("bits_pending", bq.size(), 0);
        chk("sync_pending", seq.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
